// File: rtl/fifo_flops_push_credit_vc.sv
// fifo_flops_push_credit_vc: multi-channel flop FIFO with per-channel credit mirror, credit return and round-robin pop
module fifo_flops_push_credit_vc #(
  parameter int NUM_CHANNELS = 2,
  parameter int DEPTH = 4,
  parameter int DATA_WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int CHW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_sender_in_reset,
  output logic                         push_receiver_in_reset,
  input  logic                         push_credit_stall,
  output logic [NUM_CHANNELS-1:0]      push_credit,
  input  logic                         push_valid,
  input  logic [CHW-1:0]               push_channel,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic [NUM_CHANNELS*CW-1:0]   credit_initial_push,
  input  logic [NUM_CHANNELS*CW-1:0]   credit_withhold_push,
  output logic [NUM_CHANNELS*CW-1:0]   credit_count_push,
  output logic [NUM_CHANNELS*CW-1:0]   credit_available_push,
  output logic [NUM_CHANNELS-1:0]      push_full,
  output logic                         push_overflow,
  input  logic                         pop_ready,
  output logic                         pop_valid,
  output logic [CHW-1:0]               pop_channel,
  output logic [DATA_WIDTH-1:0]        pop_data,
  output logic [NUM_CHANNELS*CW-1:0]   pop_items,
  output logic [NUM_CHANNELS-1:0]      pop_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DMAX = CW'(DEPTH);
  typedef enum logic [1:0] {INIT, RUN, SRST} state_t;
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt [NUM_CHANNELS];
  logic [CW-1:0] r_pend [NUM_CHANNELS];
  logic [CW-1:0] r_items [NUM_CHANNELS];
  logic [PW-1:0] r_wp [NUM_CHANNELS];
  logic [PW-1:0] r_rp [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] r_mem [NUM_CHANNELS][DEPTH];
  logic [CW-1:0] w_init [NUM_CHANNELS];
  logic [CW-1:0] w_avail [NUM_CHANNELS];
  logic [CW-1:0] w_cnt_nx [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_pc, w_push, w_pop, w_ret, w_empty;
  logic [CHW-1:0] r_rr, r_lock_ch, w_sel;
  logic r_lock, r_overflow, w_run, w_flush, w_acc, w_found;
  assign w_run = r_state == RUN && !push_sender_in_reset;
  assign w_flush = r_state == SRST || (r_state == RUN && push_sender_in_reset);
  assign w_acc = push_valid && w_run && int'(push_channel) < NUM_CHANNELS && w_avail[push_channel] != '0;
  assign push_receiver_in_reset = r_state != RUN || push_sender_in_reset;
  assign push_overflow = r_overflow;
  assign push_credit = r_pc;
  assign pop_valid = |(~w_empty);
  assign pop_channel = w_sel;
  assign pop_empty = w_empty;
  assign pop_data = pop_valid ? r_mem[w_sel][r_rp[w_sel]] : '0;
  always_comb w_state_nx = r_state == INIT ? RUN : push_sender_in_reset ? SRST : r_state == SRST ? INIT : RUN;
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_init[c] = credit_initial_push[c*CW +: CW] > DMAX ? DMAX : credit_initial_push[c*CW +: CW];
      w_avail[c] = r_cnt[c] > credit_withhold_push[c*CW +: CW] ? r_cnt[c] - credit_withhold_push[c*CW +: CW] : '0;
      w_empty[c] = r_items[c] == '0;
    end
  end
  // A held (stalled) presentation keeps its channel even if an earlier channel fills meanwhile
  always_comb begin
    int j;
    w_sel = r_lock_ch;
    w_found = r_lock;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      j = int'(r_rr) + i;
      j = j >= NUM_CHANNELS ? j - NUM_CHANNELS : j;
      if (!w_found && !w_empty[j]) begin
        w_sel = CHW'(j);
        w_found = 1'b1;
      end
    end
  end
  always_comb begin
    w_push = '0;
    w_pop = '0;
    w_ret = '0;
    push_full = '0;
    credit_count_push = '0;
    credit_available_push = '0;
    pop_items = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_push[c] = w_acc && push_channel == CHW'(c);
      w_pop[c] = pop_valid && pop_ready && w_sel == CHW'(c);
      w_ret[c] = w_run && !push_credit_stall && r_pend[c] != '0;
      w_cnt_nx[c] = (w_ret[c] && !w_push[c] && r_cnt[c] == DMAX) ? DMAX : r_cnt[c] - CW'(w_push[c]) + CW'(w_ret[c]);
      push_full[c] = w_avail[c] == '0;
      credit_count_push[c*CW +: CW] = r_cnt[c];
      credit_available_push[c*CW +: CW] = w_avail[c];
      pop_items[c*CW +: CW] = r_items[c];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_rr <= '0;
      r_lock <= 1'b0;
      r_lock_ch <= '0;
      r_overflow <= 1'b0;
      r_pc <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_cnt[c] <= '0;
        r_pend[c] <= '0;
        r_items[c] <= '0;
        r_wp[c] <= '0;
        r_rp[c] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_overflow <= r_overflow | (push_valid && w_run && !w_acc);
      r_lock <= !w_flush && pop_valid && !pop_ready;
      r_lock_ch <= w_sel;
      r_pc <= w_ret;
      if (pop_valid && pop_ready) r_rr <= w_sel == CHW'(NUM_CHANNELS - 1) ? '0 : w_sel + CHW'(1);
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_cnt[c] <= (r_state == INIT || w_flush) ? w_init[c] : w_cnt_nx[c];
        r_pend[c] <= w_flush ? '0 : r_pend[c] + CW'(w_pop[c]) - CW'(w_ret[c]);
        r_items[c] <= w_flush ? '0 : r_items[c] + CW'(w_push[c]) - CW'(w_pop[c]);
        r_wp[c] <= w_flush ? '0 : !w_push[c] ? r_wp[c] : r_wp[c] == PW'(DEPTH - 1) ? '0 : r_wp[c] + PW'(1);
        r_rp[c] <= w_flush ? '0 : !w_pop[c] ? r_rp[c] : r_rp[c] == PW'(DEPTH - 1) ? '0 : r_rp[c] + PW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (w_push[c]) r_mem[c][r_wp[c]] <= push_data;
  end
endmodule

// File: tb/tb_fifo_flops_push_credit_vc.sv
// tb_fifo_flops_push_credit_vc: directed scenario tasks plus randomized traffic against a queue-based model
module tb_fifo_flops_push_credit_vc;
  localparam int NC = 2;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n, push_sender_in_reset, push_receiver_in_reset, push_credit_stall;
  logic [1:0] push_credit, push_full, pop_empty;
  logic push_valid, push_overflow, pop_ready, pop_valid;
  logic [0:0] push_channel, pop_channel;
  logic [7:0] push_data, pop_data;
  logic [5:0] credit_initial_push, credit_withhold_push, credit_count_push, credit_available_push, pop_items;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  fifo_flops_push_credit_vc #(.NUM_CHANNELS(NC), .DEPTH(D), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .push_sender_in_reset(push_sender_in_reset),
    .push_receiver_in_reset(push_receiver_in_reset), .push_credit_stall(push_credit_stall),
    .push_credit(push_credit), .push_valid(push_valid), .push_channel(push_channel),
    .push_data(push_data), .credit_initial_push(credit_initial_push),
    .credit_withhold_push(credit_withhold_push), .credit_count_push(credit_count_push),
    .credit_available_push(credit_available_push), .push_full(push_full),
    .push_overflow(push_overflow), .pop_ready(pop_ready), .pop_valid(pop_valid),
    .pop_channel(pop_channel), .pop_data(pop_data), .pop_items(pop_items), .pop_empty(pop_empty));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ch, input logic [7:0] d);
    push_valid = 1'b1;
    push_channel = ch;
    push_data = d;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    push_sender_in_reset = 0; push_credit_stall = 0; push_valid = 0; push_channel = 0; push_data = 0;
    pop_ready = 0; credit_initial_push = 6'o44; credit_withhold_push = 6'o00;
    repeat (2) tick();
    n_cmp++; if (credit_count_push !== 6'o00) begin n_err++; $display("FAIL reset_count got=%o exp=00", credit_count_push); end
    n_cmp++; if (push_full !== 2'b11 || pop_empty !== 2'b11) begin n_err++; $display("FAIL reset_full_empty got=%b/%b exp=11/11", push_full, pop_empty); end
    n_cmp++; if ({pop_valid, push_overflow, push_credit, push_receiver_in_reset} !== 5'b00001) begin n_err++; $display("FAIL reset_flags got=%b exp=00001", {pop_valid, push_overflow, push_credit, push_receiver_in_reset}); end
    n_cmp++; if (pop_items !== 6'o00 || pop_data !== 8'h00 || credit_available_push !== 6'o00) begin n_err++; $display("FAIL reset_items_data got=%o/%h/%o exp=00/00/00", pop_items, pop_data, credit_available_push); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (push_receiver_in_reset !== 1'b1) begin n_err++; $display("FAIL init_not_ready got=%b exp=1", push_receiver_in_reset); end
    tick();
    n_cmp++; if (credit_count_push !== 6'o44 || credit_available_push !== 6'o44) begin n_err++; $display("FAIL init_credits got=%o/%o exp=44/44", credit_count_push, credit_available_push); end
    n_cmp++; if ({push_full, pop_empty, push_receiver_in_reset} !== 5'b00110) begin n_err++; $display("FAIL init_flags got=%b exp=00110", {push_full, pop_empty, push_receiver_in_reset}); end
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_d [6] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hA3};
    int pulses = 0;
    for (int i = 0; i < 4; i++) push(1'b0, 8'hA0 + 8'(i));
    push(1'b1, 8'hB0);
    push(1'b1, 8'hB1);
    n_cmp++; if (pop_items !== 6'o24 || credit_count_push !== 6'o20 || push_full !== 2'b01) begin n_err++; $display("FAIL rr_fill got=%o/%o/%b exp=24/20/01", pop_items, credit_count_push, push_full); end
    pop_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (pop_valid !== 1'b1 || pop_data !== exp_d[k]) begin n_err++; $display("FAIL rr_order[%0d] got=%b/%h exp=1/%h", k, pop_valid, pop_data, exp_d[k]); end
      tick();
      pulses += $countones(push_credit);
    end
    pop_ready = 1'b0;
    repeat (4) begin tick(); pulses += $countones(push_credit); end
    n_cmp++; if (pulses != 6) begin n_err++; $display("FAIL rr_pulses got=%0d exp=6", pulses); end
    n_cmp++; if (pop_items !== 6'o00 || credit_count_push !== 6'o44) begin n_err++; $display("FAIL rr_drain got=%o/%o exp=00/44", pop_items, credit_count_push); end
  endtask

  task automatic test_withhold_overflow;
    credit_withhold_push = 6'o01;
    #1;
    n_cmp++; if (credit_available_push !== 6'o43 || push_full !== 2'b00) begin n_err++; $display("FAIL wh_avail got=%o/%b exp=43/00", credit_available_push, push_full); end
    for (int i = 0; i < 3; i++) push(1'b0, 8'hD0 + 8'(i));
    n_cmp++; if (push_full !== 2'b01 || push_overflow !== 1'b0 || credit_available_push !== 6'o40) begin n_err++; $display("FAIL wh_full got=%b/%b/%o exp=01/0/40", push_full, push_overflow, credit_available_push); end
    push(1'b0, 8'hDF);
    n_cmp++; if (push_overflow !== 1'b1 || pop_items !== 6'o03) begin n_err++; $display("FAIL wh_overflow got=%b/%o exp=1/03", push_overflow, pop_items); end
  endtask

  task automatic test_stall;
    push_credit_stall = 1'b1;
    pop_ready = 1'b1;
    repeat (2) begin
      tick();
      n_cmp++; if (push_credit !== 2'b00) begin n_err++; $display("FAIL stall_pop_credit got=%b exp=00", push_credit); end
    end
    pop_ready = 1'b0;
    repeat (3) tick();
    n_cmp++; if (push_credit !== 2'b00 || credit_count_push !== 6'o41 || pop_items !== 6'o01) begin n_err++; $display("FAIL stall_hold got=%b/%o/%o exp=00/41/01", push_credit, credit_count_push, pop_items); end
    push_credit_stall = 1'b0;
    tick();
    n_cmp++; if (push_credit !== 2'b01 || credit_count_push !== 6'o42) begin n_err++; $display("FAIL stall_rel1 got=%b/%o exp=01/42", push_credit, credit_count_push); end
    tick();
    n_cmp++; if (push_credit !== 2'b01 || credit_count_push !== 6'o43) begin n_err++; $display("FAIL stall_rel2 got=%b/%o exp=01/43", push_credit, credit_count_push); end
    tick();
    n_cmp++; if (push_credit !== 2'b00 || credit_count_push !== 6'o43) begin n_err++; $display("FAIL stall_rel3 got=%b/%o exp=00/43", push_credit, credit_count_push); end
    credit_withhold_push = 6'o00;
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    repeat (2) tick();
    n_cmp++; if (credit_count_push !== 6'o44 || pop_items !== 6'o00 || push_overflow !== 1'b1) begin n_err++; $display("FAIL stall_drain got=%o/%o/%b exp=44/00/1", credit_count_push, pop_items, push_overflow); end
  endtask

  task automatic test_hold;
    push(1'b0, 8'hC0);
    push(1'b0, 8'hC1);
    push(1'b1, 8'hC2);
    push(1'b1, 8'hC3);
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if ({pop_valid, pop_channel, pop_data, pop_items} !== {1'b1, 1'b0, 8'hC0, 6'o22}) begin n_err++; $display("FAIL hold[%0d] got=%b/%b/%h/%o exp=1/0/c0/22", k, pop_valid, pop_channel, pop_data, pop_items); end
      tick();
    end
  endtask

  task automatic test_sender_reset;
    push_sender_in_reset = 1'b1;
    credit_initial_push = 6'o32;
    #1;
    n_cmp++; if (push_receiver_in_reset !== 1'b1) begin n_err++; $display("FAIL srst_comb got=%b exp=1", push_receiver_in_reset); end
    tick();
    n_cmp++; if (pop_empty !== 2'b11 || pop_valid !== 1'b0 || credit_count_push !== 6'o32 || push_credit !== 2'b00) begin n_err++; $display("FAIL srst_flush got=%b/%b/%o/%b exp=11/0/32/00", pop_empty, pop_valid, credit_count_push, push_credit); end
    push_sender_in_reset = 1'b0;
    #1;
    n_cmp++; if (push_receiver_in_reset !== 1'b1) begin n_err++; $display("FAIL srst_still got=%b exp=1", push_receiver_in_reset); end
    tick();
    n_cmp++; if (push_receiver_in_reset !== 1'b1) begin n_err++; $display("FAIL srst_init got=%b exp=1", push_receiver_in_reset); end
    tick();
    n_cmp++; if (push_receiver_in_reset !== 1'b0 || credit_count_push !== 6'o32) begin n_err++; $display("FAIL srst_ready got=%b/%o exp=0/32", push_receiver_in_reset, credit_count_push); end
  endtask

  task automatic test_async_reset;
    credit_initial_push = 6'o44;
    push(1'b0, 8'hE0);
    push(1'b1, 8'hE1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if ({pop_valid, push_overflow, push_receiver_in_reset, push_full, pop_empty} !== 7'b0011111) begin n_err++; $display("FAIL arst_flags got=%b exp=0011111", {pop_valid, push_overflow, push_receiver_in_reset, push_full, pop_empty}); end
    n_cmp++; if (pop_items !== 6'o00 || credit_count_push !== 6'o00 || pop_data !== 8'h00) begin n_err++; $display("FAIL arst_vals got=%o/%o/%h exp=00/00/00", pop_items, credit_count_push, pop_data); end
    tick();
    rst_n = 1'b1;
    push_valid = 1'b1; push_channel = 1'b0; push_data = 8'hFF;
    tick();
    push_valid = 1'b0;
    #1;
    n_cmp++; if (pop_items !== 6'o00 || credit_count_push !== 6'o44 || push_receiver_in_reset !== 1'b0) begin n_err++; $display("FAIL arst_release_push got=%o/%o/%b exp=00/44/0", pop_items, credit_count_push, push_receiver_in_reset); end
  endtask

  task automatic test_random;
    logic [7:0] mq [NC][$];
    int mcnt [NC], mpend [NC], wh [NC], av [NC];
    bit mpc [NC], ret [NC];
    int mrr = 0, mlock_ch = 0, es, j;
    bit mlock = 0, movf = 0, ev, acc;
    for (int c = 0; c < NC; c++) begin mcnt[c] = D; mpend[c] = 0; mpc[c] = 0; wh[c] = $urandom_range(0, 1); end
    credit_withhold_push = {3'(wh[1]), 3'(wh[0])};
    for (int cyc = 0; cyc < 400; cyc++) begin
      push_valid = 1'($urandom_range(0, 1));
      push_channel = 1'($urandom_range(0, 1));
      push_data = 8'($urandom);
      push_credit_stall = $urandom_range(0, 4) == 0;
      pop_ready = $urandom_range(0, 2) != 0;
      #1;
      ev = mq[0].size() != 0 || mq[1].size() != 0;
      es = mlock_ch;
      if (!mlock)
        for (int i = NC - 1; i >= 0; i--) begin j = (mrr + i) % NC; if (mq[j].size() != 0) es = j; end
      for (int c = 0; c < NC; c++) av[c] = mcnt[c] > wh[c] ? mcnt[c] - wh[c] : 0;
      n_cmp++; if (pop_valid !== ev) begin n_err++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, pop_valid, ev); end
      if (ev) begin
        n_cmp++; if (pop_channel !== 1'(es) || pop_data !== mq[es][0]) begin n_err++; $display("FAIL rnd_head[%0d] got=%b/%h exp=%0d/%h", cyc, pop_channel, pop_data, es, mq[es][0]); end
      end
      n_cmp++; if (pop_items !== {3'(mq[1].size()), 3'(mq[0].size())} || credit_count_push !== {3'(mcnt[1]), 3'(mcnt[0])}) begin n_err++; $display("FAIL rnd_levels[%0d] got=%o/%o exp=%0d%0d/%0d%0d", cyc, pop_items, credit_count_push, mq[1].size(), mq[0].size(), mcnt[1], mcnt[0]); end
      n_cmp++; if (push_credit !== {mpc[1], mpc[0]} || push_full !== {av[1] == 0, av[0] == 0} || push_overflow !== movf) begin n_err++; $display("FAIL rnd_flags[%0d] got=%b/%b/%b exp=%b%b/%b%b/%b", cyc, push_credit, push_full, push_overflow, mpc[1], mpc[0], av[1] == 0, av[0] == 0, movf); end
      for (int c = 0; c < NC; c++) ret[c] = !push_credit_stall && mpend[c] > 0;
      acc = push_valid && av[push_channel] > 0;
      if (push_valid && !acc) movf = 1;
      if (ev && pop_ready) begin
        void'(mq[es].pop_front());
        mpend[es]++;
        mrr = (es + 1) % NC;
      end
      mlock = ev && !pop_ready;
      mlock_ch = es;
      if (acc) begin mq[push_channel].push_back(push_data); mcnt[push_channel]--; end
      for (int c = 0; c < NC; c++) begin
        if (ret[c]) begin mpend[c]--; if (mcnt[c] < D) mcnt[c]++; end
        mpc[c] = ret[c];
      end
      tick();
    end
    push_valid = 1'b0; push_credit_stall = 1'b0; pop_ready = 1'b1;
    repeat (20) tick();
    n_cmp++; if (credit_count_push !== 6'o44 || pop_items !== 6'o00 || push_credit !== 2'b00) begin n_err++; $display("FAIL rnd_conserve got=%o/%o/%b exp=44/00/00", credit_count_push, pop_items, push_credit); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_withhold_overflow();
    test_stall();
    test_hold();
    test_sender_reset();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_flops_push_credit_vc.md
# fifo_flops_push_credit_vc

Single-clock, multi-channel credit-flow FIFO: NUM_CHANNELS independent flop-based queues share one push port and one pop port. Each channel has its own credit counter, credit withhold and credit-return path. The block is the receiver-side buffer for virtual-channel links inside one clock domain. It also keeps a sender-side credit mirror so that pushes without credit are rejected and flagged. Pop-side arbitration across non-empty channels is round-robin.

## Interface
Parameters:
- NUM_CHANNELS, 2: number of virtual channels (≥1).
- DEPTH, 4: entries per channel (≥2).
- DATA_WIDTH, 8: payload width.
- CW (derived), $clog2(DEPTH+1): credit/count width.
- CHW (derived), max(1,$clog2(NUM_CHANNELS)): channel-index width.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- push_sender_in_reset  in  1  sender requests link reset.
- push_receiver_in_reset  out  1  block not ready to accept traffic.
- push_credit_stall  in  1  hold all credit returns.
- push_credit  out  NUM_CHANNELS  per-channel one-cycle credit-return pulse.
- push_valid  in  1  push request.
- push_channel  in  CHW  target channel.
- push_data  in  DATA_WIDTH  payload.
- credit_initial_push  in  NUM_CHANNELS*CW  initial credits per channel, packed; channel c at [c*CW +: CW].
- credit_withhold_push  in  NUM_CHANNELS*CW  credits withheld per channel, packed.
- credit_count_push  out  NUM_CHANNELS*CW  sender credit mirror.
- credit_available_push  out  NUM_CHANNELS*CW  count minus withhold, floored at 0.
- push_full  out  NUM_CHANNELS  credit_available==0 per channel.
- push_overflow  out  1  sticky: push attempted with no credit.
- pop_ready  in  1  consumer ready.
- pop_valid  out  1  some channel non-empty.
- pop_channel  out  CHW  channel presented.
- pop_data  out  DATA_WIDTH  head of presented channel.
- pop_items  out  NUM_CHANNELS*CW  occupancy per channel.
- pop_empty  out  NUM_CHANNELS  occupancy==0 per channel.

## Operation
- State machine has three states:
  - INIT: entered on rst_n low. On the first clk edge with rst_n high, every credit_count loads min(credit_initial, DEPTH), then the FSM goes to RUN.
  - RUN: normal operation. push_sender_in_reset=1 causes a transition to SRST.
  - SRST: all queues are flushed, pending returns and push_credit are cleared, and credit_count reloads credit_initial every cycle. push_sender_in_reset=0 causes a transition to INIT.
- push_receiver_in_reset=1 in INIT and SRST, and combinationally whenever push_sender_in_reset=1.
- Push is accepted when push_valid=1, the FSM is in RUN, push_sender_in_reset=0, push_channel<NUM_CHANNELS and credit_available[ch]>0. An accepted push:
  - writes the tail of channel ch;
  - increments pop_items[ch];
  - decrements credit_count[ch].
- Push is dropped (no write) when push_valid=1 in RUN but credit_available[ch]==0 or the channel index is out of range. A dropped push sets push_overflow, which clears only on reset.
- Pushes in INIT or SRST are ignored silently.
- Pop: pop_valid = OR of ~pop_empty. The round-robin pointer selects the first non-empty channel at or after the pointer. The selection is held while pop_valid && !pop_ready.
  - A pop occurs when pop_valid && pop_ready. It removes the head and moves the pointer to pop_channel+1, wrapping at NUM_CHANNELS.
- Credit return, per channel:
  - Each pop increments pending[c].
  - On each edge where push_credit_stall=0 and pending[c]>0, push_credit[c] is registered to 1 and pending[c] decrements; otherwise push_credit[c] is 0.
  - credit_count[c] increments on the same edge that registers push_credit[c]=1.
- Arithmetic:
  - A push and a credit return on the same channel in the same cycle leave the count unchanged.
  - Counts never exceed DEPTH and never wrap.
  - credit_available = count>withhold ? count−withhold : 0.
- A push and a pop on the same channel in the same cycle are both performed; occupancy is unchanged.

## Timing
- Reset values, all outputs: push_credit=0, push_overflow=0, pop_valid=0, pop_items=0, pop_empty all 1, credit_count=0, credit_available=0, push_full all 1, push_receiver_in_reset=1, pop_data=0.
- Push at edge N: pop_valid, pop_items and pop_data are visible after N (zero-bubble first-word fall-through).
- Pop at edge N: pending[c] is incremented at N.
  - With no stall, push_credit[c]=1 during the cycle after N+1, and credit_count[c] is +1 at N+1.
  - Minimum pop-to-credit latency is 1 cycle. Sustained throughput is 1 credit per channel per cycle.
- Stall released at edge S: returns resume at S+1, one per channel per cycle, until pending reaches 0.
- rst_n assertion mid-operation clears all state immediately (asynchronously). A push coincident with the reset-release edge is ignored because the FSM is still in INIT.

## Test plan
- Reset, initial=4/4, withhold=0/0: after release plus 1 edge, credit_count=4/4, available=4/4, push_full=0, pop_empty=11, push_receiver_in_reset=0.
- Push A0..A3 to ch0, B0,B1 to ch1, then pop_ready=1: pop order A0,B0,A1,B1,A2,A3 (round-robin); pop_items returns to 0; six push_credit pulses total; counts restored to 4/4.
- Withhold ch0=1: 3 pushes set push_full[0]. A 4th push sets push_overflow=1 and leaves pop_items[0]=3.
- push_credit_stall=1, pop 2 from ch0: push_credit stays 0 and count[0] is unchanged. Release the stall: 2 pulses on consecutive cycles and count[0] +2.
- pop_ready=0 with both channels non-empty for 10 cycles: pop_channel and pop_data stable, items unchanged.
- push_sender_in_reset=1 with data queued: pop_empty=11 next cycle, counts=initial, push_receiver_in_reset=1. Deassert: ready 2 edges later. Asserting rst_n=0 mid-traffic clears outputs immediately.
